// File: rtl/pc_branch_pkg.sv
// Shared constants, counter type and saturating update for the PC/branch unit.
package pc_branch_pkg;

   localparam int unsigned CTR_W = 2;
   localparam int unsigned KIND_W = 2;

   localparam logic [KIND_W-1:0] BR_JR   = 2'b00;
   localparam logic [KIND_W-1:0] BR_J    = 2'b01;
   localparam logic [KIND_W-1:0] BR_COND = 2'b10;
   localparam logic [KIND_W-1:0] BR_NONE = 2'b11;

   localparam logic [KIND_W-1:0] PCS_JR  = 2'b00;
   localparam logic [KIND_W-1:0] PCS_J   = 2'b01;
   localparam logic [KIND_W-1:0] PCS_BR  = 2'b10;
   localparam logic [KIND_W-1:0] PCS_SEQ = 2'b11;

   typedef logic [CTR_W-1:0] ctr_t;

   // Two-bit saturating step toward taken / not-taken.
   function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
      ctr_t r;
      r = c;
      if (taken) begin
         if (c != 2'b11) r = c + CTR_W'(1);
      end else begin
         if (c != 2'b00) r = c - CTR_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/bht_bimodal.sv
// Bimodal branch history table: 2-bit counters, async read, sync update.
module bht_bimodal
   import pc_branch_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter ctr_t        CTR_INIT = 2'b01,
   localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx_i,
   output ctr_t             rd_ctr_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   ctr_t ctr_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) ctr_q[i] <= CTR_INIT;
      end else if (wr_en_i) begin
         ctr_q[wr_idx_i] <= ctr_update(ctr_q[wr_idx_i], wr_taken_i);
      end
   end

   // Read sees the pre-update value when the same entry is written this cycle.
   assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, decode-time bimodal prediction, EX resolution/recovery and branch statistics.
module pc_branch_unit
   import pc_branch_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       BHT_DEPTH = 16,
   parameter ctr_t              CTR_INIT  = 2'b01,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              dec_valid,
   input  logic              dec_is_cond,
   input  logic [ADDR_W-1:0] dec_pc,
   input  logic [ADDR_W-1:0] dec_target,
   output logic              pred_taken,
   input  logic              ex_valid,
   input  logic [1:0]        ex_branch,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic [ADDR_W-1:0] ex_target,
   input  logic [31:0]       alu_result,
   input  logic              ex_pred_taken,
   output logic [ADDR_W-1:0] pc,
   output logic [1:0]        pc_src,
   output logic              flush_fetch,
   output logic              flush_decode,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  mispred_cnt
);

   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;
   logic              ex_redirect;
   logic              cond_resolve;
   logic              mispredict;
   logic              taken;
   ctr_t              rd_ctr;
   logic              unused_pc_bits;

   bht_bimodal #(
      .DEPTH    (BHT_DEPTH),
      .CTR_INIT (CTR_INIT)
   ) u_bht (
      .clk        (clk),
      .reset      (reset),
      .rd_idx_i   (dec_pc[2 +: IDX_W]),
      .rd_ctr_o   (rd_ctr),
      .wr_en_i    (cond_resolve),
      .wr_idx_i   (ex_pc[2 +: IDX_W]),
      .wr_taken_i (taken)
   );

   assign pred_taken     = rd_ctr[1];
   assign unused_pc_bits = ^{dec_pc, ex_pc};

   // Next-PC selection: stall > EX redirect > decode prediction > sequential.
   always_comb begin
      pc_d         = pc_q + ADDR_W'(4);
      pc_src       = PCS_SEQ;
      flush_fetch  = 1'b0;
      flush_decode = 1'b0;
      ex_redirect  = 1'b0;
      cond_resolve = 1'b0;
      mispredict   = 1'b0;
      taken        = |alu_result;
      if (!reset) begin
         pc_d = RESET_PC;
      end else if (stall) begin
         pc_d = pc_q;
      end else begin
         if (ex_valid) begin
            case (ex_branch)
               BR_JR: begin
                  ex_redirect = 1'b1;
                  pc_d        = ex_target;
                  pc_src      = PCS_JR;
               end
               BR_J: begin
                  ex_redirect = 1'b1;
                  pc_d        = ex_target;
                  pc_src      = PCS_J;
               end
               BR_COND: begin
                  cond_resolve = 1'b1;
                  mispredict   = taken != ex_pred_taken;
                  if (mispredict) begin
                     ex_redirect = 1'b1;
                     if (taken) begin
                        pc_d   = ex_target;
                        pc_src = PCS_BR;
                     end else begin
                        pc_d   = ex_pc + ADDR_W'(4);
                        pc_src = PCS_SEQ;
                     end
                  end
               end
               default: ;
            endcase
         end
         if (ex_redirect) begin
            flush_fetch  = 1'b1;
            flush_decode = 1'b1;
         end else if (dec_valid && dec_is_cond && pred_taken) begin
            pc_d        = dec_target;
            pc_src      = PCS_BR;
            flush_fetch = 1'b1;
         end
      end
   end

   // Statistics saturate at all-ones.
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (cond_resolve && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         pc_q          <= pc_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign pc          = pc_q;
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
